// File: rtl/zbt_framestore_arbiter_if.sv
// Requester, flush and ZBT pin bundle for one framestore bank arbiter.
// slave is the arbiter side; master is the decoder/SRAM side.
interface zbt_framestore_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 32
);
  logic              disp_req;
  logic              wb_req;
  logic              fwd_req;
  logic              bwd_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [ADDR_W-1:0] wb_addr;
  logic [ADDR_W-1:0] fwd_addr;
  logic [ADDR_W-1:0] bwd_addr;
  logic [DATA_W-1:0] wb_data;
  logic              disp_busy;
  logic              wb_busy;
  logic              fwd_busy;
  logic              bwd_busy;
  logic              disp_valid;
  logic              fwd_valid;
  logic              bwd_valid;
  logic [DATA_W-1:0] rdata;
  logic              flush;
  logic              flush_done;
  logic [ADDR_W-1:0] zbt_address;
  logic              zbt_we_n;
  logic [DATA_W-1:0] zbt_wdata;
  logic              zbt_data_oe;
  logic [DATA_W-1:0] zbt_rdata;

  modport slave (
    input  disp_req, wb_req, fwd_req, bwd_req,
           disp_addr, wb_addr, fwd_addr, bwd_addr, wb_data,
           flush, zbt_rdata,
    output disp_busy, wb_busy, fwd_busy, bwd_busy,
           disp_valid, fwd_valid, bwd_valid, rdata, flush_done,
           zbt_address, zbt_we_n, zbt_wdata, zbt_data_oe
  );

  modport master (
    output disp_req, wb_req, fwd_req, bwd_req,
           disp_addr, wb_addr, fwd_addr, bwd_addr, wb_data,
           flush, zbt_rdata,
    input  disp_busy, wb_busy, fwd_busy, bwd_busy,
           disp_valid, fwd_valid, bwd_valid, rdata, flush_done,
           zbt_address, zbt_we_n, zbt_wdata, zbt_data_oe
  );
endinterface

// File: rtl/zbt_framestore_arbiter.sv
// Four-way ZBT framestore arbiter: one access per cycle, read data tagged back RD_LATENCY+2 after accept.
// Busy is combinational per requester; flush blocks all requesters until the pipeline has drained.
module zbt_framestore_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic                       clock,
  input  logic                       resetn,
  zbt_framestore_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;
  typedef enum logic [1:0] {TAG_DISP = 2'd0, TAG_FWD = 2'd1, TAG_BWD = 2'd2} tag_t;

  localparam int              CNT_W      = 3;
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(RD_LATENCY + 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              accept_en;
  logic              blocked;
  logic              mc_pick_bwd;

  logic              gnt_disp, gnt_wb, gnt_fwd, gnt_bwd, gnt_rd;
  logic [ADDR_W-1:0] gnt_addr;
  tag_t              gnt_tag;

  logic [RD_LATENCY:0]   tag_vld;
  tag_t                  tag_pipe [0:RD_LATENCY];
  logic [RD_LATENCY-1:0] wr_vld;
  logic [DATA_W-1:0]     wr_pipe  [0:RD_LATENCY-1];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept_en = 1'b0;
    case (state)
      RUN: begin
        if (bus.flush) begin
          state_nxt = DRAIN;
          cnt_nxt   = DRAIN_LOAD;
        end else begin
          accept_en = resetn;
        end
      end
      DRAIN: begin
        if (cnt == '0) state_nxt = DONE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      DONE:    state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Display beats write-back beats the MC pair; the MC pair alternates when both ask.
  always_comb begin
    gnt_disp = 1'b0;
    gnt_wb   = 1'b0;
    gnt_fwd  = 1'b0;
    gnt_bwd  = 1'b0;
    gnt_addr = bus.disp_addr;
    gnt_tag  = TAG_DISP;
    if (accept_en) begin
      if (bus.disp_req) begin
        gnt_disp = 1'b1;
      end else if (bus.wb_req) begin
        gnt_wb   = 1'b1;
        gnt_addr = bus.wb_addr;
      end else if (bus.fwd_req && (!bus.bwd_req || !mc_pick_bwd)) begin
        gnt_fwd  = 1'b1;
        gnt_addr = bus.fwd_addr;
        gnt_tag  = TAG_FWD;
      end else if (bus.bwd_req) begin
        gnt_bwd  = 1'b1;
        gnt_addr = bus.bwd_addr;
        gnt_tag  = TAG_BWD;
      end
    end
  end

  assign gnt_rd  = gnt_disp || gnt_fwd || gnt_bwd;
  assign blocked = !resetn || (state != RUN);

  assign bus.disp_busy  = blocked || (bus.disp_req && !gnt_disp);
  assign bus.wb_busy    = blocked || (bus.wb_req   && !gnt_wb);
  assign bus.fwd_busy   = blocked || (bus.fwd_req  && !gnt_fwd);
  assign bus.bwd_busy   = blocked || (bus.bwd_req  && !gnt_bwd);
  assign bus.flush_done = (state == DONE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= RUN;
      cnt         <= '0;
      mc_pick_bwd <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (gnt_fwd || gnt_bwd) mc_pick_bwd <= gnt_fwd;
    end
  end

  // Late-write ZBT: write data trails its address by RD_LATENCY, same as read data,
  // so reads and writes can be mixed back to back without turnaround.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bus.zbt_address <= '0;
      bus.zbt_we_n    <= 1'b1;
      bus.zbt_wdata   <= '0;
      bus.zbt_data_oe <= 1'b0;
      bus.rdata       <= '0;
      bus.disp_valid  <= 1'b0;
      bus.fwd_valid   <= 1'b0;
      bus.bwd_valid   <= 1'b0;
      tag_vld         <= '0;
      wr_vld          <= '0;
      for (int k = 0; k <= RD_LATENCY; k++) tag_pipe[k] <= TAG_DISP;
      for (int k = 0; k < RD_LATENCY; k++)  wr_pipe[k]  <= '0;
    end else begin
      if (gnt_rd || gnt_wb) bus.zbt_address <= gnt_addr;
      bus.zbt_we_n <= !gnt_wb;

      tag_vld[0]  <= gnt_rd;
      tag_pipe[0] <= gnt_tag;
      for (int k = 1; k <= RD_LATENCY; k++) begin
        tag_vld[k]  <= tag_vld[k-1];
        tag_pipe[k] <= tag_pipe[k-1];
      end

      wr_vld[0]  <= gnt_wb;
      wr_pipe[0] <= bus.wb_data;
      for (int k = 1; k < RD_LATENCY; k++) begin
        wr_vld[k]  <= wr_vld[k-1];
        wr_pipe[k] <= wr_pipe[k-1];
      end

      bus.zbt_data_oe <= wr_vld[RD_LATENCY-1];
      bus.zbt_wdata   <= wr_vld[RD_LATENCY-1] ? wr_pipe[RD_LATENCY-1] : '0;

      bus.disp_valid <= tag_vld[RD_LATENCY] && (tag_pipe[RD_LATENCY] == TAG_DISP);
      bus.fwd_valid  <= tag_vld[RD_LATENCY] && (tag_pipe[RD_LATENCY] == TAG_FWD);
      bus.bwd_valid  <= tag_vld[RD_LATENCY] && (tag_pipe[RD_LATENCY] == TAG_BWD);
      if (tag_vld[RD_LATENCY]) bus.rdata <= bus.zbt_rdata;
    end
  end

endmodule

// File: tb/tb_zbt_framestore_arbiter.sv
// Scoreboard bench: stimulus pushes expected ZBT/valid/flush events, a monitor pops them each cycle.
module tb_zbt_framestore_arbiter;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 32;
  localparam int L      = 2;

  logic clock  = 1'b0;
  logic resetn = 1'b1;
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  zbt_framestore_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  zbt_framestore_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(L)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct { int cyc; logic [ADDR_W-1:0] addr; logic we_n; } zexp_t;
  typedef struct { int cyc; logic [DATA_W-1:0] data; } wexp_t;
  typedef struct { int cyc; int who; logic [DATA_W-1:0] data; } rexp_t;

  zexp_t q_z[$];
  wexp_t q_w[$];
  rexp_t q_r[$];
  int    q_done[$];

  // Requester ids: 0 disp, 1 wb, 2 fwd, 3 bwd.
  logic              pend [4];
  logic [ADDR_W-1:0] req_addr [4];
  logic [DATA_W-1:0] req_data;
  logic              flush_drv;
  int                blk_from, blk_to;
  int                mc_last;
  int                obs;

  logic [DATA_W-1:0] refmem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] sram   [logic [ADDR_W-1:0]];
  logic [ADDR_W-1:0] a_hist [int];
  logic              we_hist[int];

  function automatic logic [DATA_W-1:0] init_word(logic [ADDR_W-1:0] a);
    return {16'hA5A5, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_bus();
    bus.disp_req  = pend[0]; bus.disp_addr = req_addr[0];
    bus.wb_req    = pend[1]; bus.wb_addr   = req_addr[1]; bus.wb_data = req_data;
    bus.fwd_req   = pend[2]; bus.fwd_addr  = req_addr[2];
    bus.bwd_req   = pend[3]; bus.bwd_addr  = req_addr[3];
    bus.flush     = flush_drv;
  endtask

  // One clock of stimulus plus reference-model bookkeeping.
  task automatic step();
    int       g;
    bit       in_blk;
    logic [3:0] busy_exp, busy_act;
    zexp_t    z;
    wexp_t    w;
    rexp_t    r;
    logic [DATA_W-1:0] rv;
    @(posedge clock); #1;
    drive_bus();
    #3;
    in_blk = (cyc >= blk_from) && (cyc <= blk_to);
    g = -1;
    if (!in_blk) begin
      if (flush_drv) begin
        blk_from = cyc + 1;
        blk_to   = cyc + L + 3;
        q_done.push_back(cyc + L + 3);
      end
      else if (pend[0]) g = 0;
      else if (pend[1]) g = 1;
      else if (pend[2] && pend[3]) g = (mc_last == 2) ? 3 : 2;
      else if (pend[2]) g = 2;
      else if (pend[3]) g = 3;
    end
    for (int i = 0; i < 4; i++) busy_exp[i] = in_blk || (pend[i] && (g != i));
    busy_act = {bus.bwd_busy, bus.fwd_busy, bus.wb_busy, bus.disp_busy};
    chk("busy", 64'(busy_act), 64'(busy_exp));
    obs = -1;
    for (int i = 3; i >= 0; i--) if (pend[i] && !busy_act[i]) obs = i;
    if (g >= 0) begin
      z.cyc = cyc + 1; z.addr = req_addr[g]; z.we_n = (g != 1);
      q_z.push_back(z);
      if (g == 1) begin
        refmem[req_addr[1]] = req_data;
        w.cyc = cyc + 1 + L; w.data = req_data;
        q_w.push_back(w);
      end else begin
        rv = refmem.exists(req_addr[g]) ? refmem[req_addr[g]] : init_word(req_addr[g]);
        r.cyc = cyc + 2 + L; r.who = g; r.data = rv;
        q_r.push_back(r);
      end
      if (g >= 2) mc_last = g;
      pend[g] = 1'b0;
    end
    flush_drv = 1'b0;
  endtask

  task automatic reset_pulse();
    @(posedge clock); #1;
    resetn      = 1'b0;
    bus.fwd_req = 1'b1;
    bus.wb_req  = 1'b1;
    #3;
    chk("rst_busy", 64'({bus.bwd_busy, bus.fwd_busy, bus.wb_busy, bus.disp_busy}), 64'hF);
    chk("rst_we_n", 64'(bus.zbt_we_n), 64'd1);
    chk("rst_addr", 64'(bus.zbt_address), 64'd0);
    chk("rst_oe", 64'(bus.zbt_data_oe), 64'd0);
    chk("rst_wdata", 64'(bus.zbt_wdata), 64'd0);
    chk("rst_rdata", 64'(bus.rdata), 64'd0);
    chk("rst_valid", 64'({bus.disp_valid, bus.fwd_valid, bus.bwd_valid}), 64'd0);
    chk("rst_flush_done", 64'(bus.flush_done), 64'd0);
    q_z.delete(); q_w.delete(); q_r.delete(); q_done.delete();
    blk_from = -1; blk_to = -2; mc_last = 3;
    @(posedge clock); #1;
    resetn = 1'b1;
    drive_bus();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // SRAM model: read data for the address of cycle c-L is presented in cycle c; late write likewise.
  initial begin
    bus.zbt_rdata = '0;
    forever begin
      @(posedge clock); #2;
      a_hist[cyc]  = bus.zbt_address;
      we_hist[cyc] = bus.zbt_we_n;
      if (we_hist.exists(cyc - L)) begin
        if (bus.zbt_data_oe && !we_hist[cyc - L]) sram[a_hist[cyc - L]] = bus.zbt_wdata;
        if (we_hist[cyc - L])
          bus.zbt_rdata = sram.exists(a_hist[cyc - L]) ? sram[a_hist[cyc - L]]
                                                       : init_word(a_hist[cyc - L]);
      end
    end
  end

  // Monitor
  initial begin
    zexp_t z;
    wexp_t w;
    rexp_t r;
    int    nv, who;
    bit    exp_v, exp_d;
    forever begin
      @(posedge clock); #6;
      if (resetn) begin
        if (q_z.size() > 0 && q_z[0].cyc == cyc) begin
          z = q_z.pop_front();
          chk("zbt_we_n", 64'(bus.zbt_we_n), 64'(z.we_n));
          chk("zbt_addr", 64'(bus.zbt_address), 64'(z.addr));
        end else begin
          chk("zbt_idle_we_n", 64'(bus.zbt_we_n), 64'd1);
        end
        if (q_w.size() > 0 && q_w[0].cyc == cyc) begin
          w = q_w.pop_front();
          chk("zbt_oe", 64'(bus.zbt_data_oe), 64'd1);
          chk("zbt_wdata", 64'(bus.zbt_wdata), 64'(w.data));
        end else begin
          chk("zbt_idle_oe", 64'(bus.zbt_data_oe), 64'd0);
        end
        nv = int'(bus.disp_valid) + int'(bus.fwd_valid) + int'(bus.bwd_valid);
        chk("valid_count_gt1", 64'(nv > 1), 64'd0);
        exp_v = (q_r.size() > 0) && (q_r[0].cyc == cyc);
        chk("valid_present", 64'(nv > 0), 64'(exp_v));
        if (exp_v) begin
          r = q_r.pop_front();
          if (nv > 0) begin
            who = bus.disp_valid ? 0 : (bus.fwd_valid ? 2 : 3);
            chk("valid_who", 64'(who), 64'(r.who));
            chk("rdata", 64'(bus.rdata), 64'(r.data));
          end
        end
        exp_d = (q_done.size() > 0) && (q_done[0] == cyc);
        if (exp_d) void'(q_done.pop_front());
        chk("flush_done", 64'(bus.flush_done), 64'(exp_d));
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) begin pend[i] = 1'b0; req_addr[i] = '0; end
    req_data = '0; flush_drv = 1'b0;
    blk_from = -1; blk_to = -2; mc_last = 3;
    drive_bus();
    #1 resetn = 1'b0;
    reset_pulse();

    // Round robin with Fwd and Bwd both held.
    for (int k = 0; k < 6; k++) begin
      pend[2] = 1'b1; req_addr[2] = ADDR_W'(32'h100 + k);
      pend[3] = 1'b1; req_addr[3] = ADDR_W'(32'h180 + k);
      step();
      chk("rr_order", 64'(obs), 64'((k % 2 == 0) ? 2 : 3));
    end
    pend[2] = 1'b0; pend[3] = 1'b0;
    idle(6);

    // Lone Fwd read of 0x10.
    pend[2] = 1'b1; req_addr[2] = 19'h00010;
    step();
    chk("fwd_alone", 64'(obs), 64'd2);
    idle(6);

    // Disp, Wb, Fwd together.
    pend[0] = 1'b1; req_addr[0] = 19'h00020;
    pend[1] = 1'b1; req_addr[1] = 19'h00021; req_data = 32'hCAFE_0021;
    pend[2] = 1'b1; req_addr[2] = 19'h00022;
    step(); chk("prio_1st", 64'(obs), 64'd0);
    step(); chk("prio_2nd", 64'(obs), 64'd1);
    step(); chk("prio_3rd", 64'(obs), 64'd2);
    idle(6);

    // Write then immediate read of the same word.
    pend[1] = 1'b1; req_addr[1] = 19'h00200; req_data = 32'h1234_5678;
    step(); chk("raw_wr", 64'(obs), 64'd1);
    pend[0] = 1'b1; req_addr[0] = 19'h00200;
    step(); chk("raw_rd", 64'(obs), 64'd0);
    idle(6);

    // Flush right after a read, with a Bwd request colliding.
    pend[2] = 1'b1; req_addr[2] = 19'h00300;
    step(); chk("flush_pre", 64'(obs), 64'd2);
    pend[3] = 1'b1; req_addr[3] = 19'h00301; flush_drv = 1'b1;
    step(); chk("flush_blk", 64'(obs), -64'sd1);
    for (int k = 2; k <= 6; k++) begin
      step(); chk("drain_blk", 64'(obs), -64'sd1);
    end
    step(); chk("post_flush", 64'(obs), 64'd3);
    idle(8);

    // Reset while a Disp read is in flight.
    pend[0] = 1'b1; req_addr[0] = 19'h00040;
    step(); chk("pre_rst", 64'(obs), 64'd0);
    reset_pulse();
    idle(8);

    // Random traffic with occasional flushes.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend[i] && ($urandom_range(0, 99) < 30)) begin
          pend[i]     = 1'b1;
          req_addr[i] = ADDR_W'($urandom_range(0, 31));
          if (i == 1) req_data = $urandom;
        end
      end
      if ($urandom_range(0, 63) == 0) flush_drv = 1'b1;
      step();
    end
    for (int i = 0; i < 4; i++) pend[i] = 1'b0;
    idle(16);

    chk("leftover_expected", 64'(q_z.size() + q_w.size() + q_r.size() + q_done.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/zbt_framestore_arbiter.md
# zbt_framestore_arbiter

Single-port arbiter and sequencer for one ZBT SRAM framestore bank. It is shared by four requesters: display readout, YUV write-back, forward motion-compensation reads and backward motion-compensation reads. It is instantiated once per framestore bank, between the picture decoder's framestore ports and the ZBT pins. It orders accesses, pipelines ZBT address and data timing, and returns read data tagged to the originating requester.

## Interface
- ADDR_W, 19, framestore word address width
- DATA_W, 32, framestore word width
- RD_LATENCY, 2, ZBT cycles from address to read data (and address to write data); legal range 1–4
- clock  input  1  system clock, rising edge
- resetn  input  1  asynchronous, active-low reset
- Disp_Req_I / Wb_Req_I / Fwd_Req_I / Bwd_Req_I  input  1 each  access request; held with address/data until accepted
- Disp_Addr_I / Wb_Addr_I / Fwd_Addr_I / Bwd_Addr_I  input  ADDR_W each  word address
- Wb_Data_I  input  DATA_W  write-back data
- Disp_Busy_O / Wb_Busy_O / Fwd_Busy_O / Bwd_Busy_O  output  1 each  request not accepted this cycle
- Disp_Valid_O / Fwd_Valid_O / Bwd_Valid_O  output  1 each  Rdata_O belongs to this requester this cycle
- Rdata_O  output  DATA_W  registered read data
- Flush_I  input  1  stop accepting requests and drain the pipeline
- Flush_Done_O  output  1  one-cycle pulse when the drain completes
- ZBT_Address_O  output  ADDR_W  SRAM address
- ZBT_WE_n_O  output  1  SRAM write enable, active low
- ZBT_Data_O  output  DATA_W  SRAM write data
- ZBT_Data_OE_O  output  1  drive enable for the SRAM data bus
- ZBT_Data_I  input  DATA_W  SRAM read data

## Operation
- A request is accepted in any cycle where Req is high and Busy is low. Busy is combinational from the current requests and the state. A requester holds Req, Addr and Data until it is accepted.
- At most one acceptance per cycle. Fixed priority: display > write-back > MC pair.
- MC pair arbitration is round-robin on a 1-bit pointer. If both Fwd and Bwd request, the one not granted last wins. The pointer updates on every MC grant. After reset the pointer favours Fwd.
- Unaccepted requesters see Busy=1. Busy=0 for a requester whose Req is low, unless the state is DRAIN or DONE.
- Accepted read: the address goes to ZBT with WE_n=1. A 2-bit tag (disp/fwd/bwd) plus a valid bit enters a RD_LATENCY+1-deep shift register.
- Accepted write: the address goes to ZBT with WE_n=0. Wb_Data is pushed into a RD_LATENCY-deep data pipeline and driven with OE=1 exactly RD_LATENCY cycles after its address (ZBT late write, so no turnaround cycles are needed).
- Idle cycle: WE_n=1, the address holds its last value, and the tag is invalid, so the returned data is discarded.
- State machine:
  - RUN: normal operation. Flush_I moves to DRAIN; a request arriving in the same cycle as Flush_I is not accepted.
  - DRAIN: all Busy=1. A counter loaded with RD_LATENCY+1 on entry decrements each cycle. At 0, move to DONE.
  - DONE: Flush_Done_O=1 for one cycle, all Busy=1, then move to RUN.
  - Flush_I asserted during DRAIN or DONE is ignored.
- Reset: state=RUN, pointer=Fwd, all pipelines cleared. An in-flight read is lost with no Valid, and a pending write is not driven.

## Timing
- Request accepted in cycle T:
  - ZBT_Address_O/ZBT_WE_n_O registered, valid in cycle T+1.
  - Write: ZBT_Data_O valid with OE=1 in cycle T+1+RD_LATENCY.
  - Read: ZBT_Data_I sampled at the end of cycle T+1+RD_LATENCY. Rdata_O and the matching Valid are high in cycle T+2+RD_LATENCY, i.e. 4 cycles after acceptance with the default latency.
- Throughput is one access per cycle with any mix of reads and writes.
- At most one Valid_O is high per cycle. Valid pulses follow acceptance order.
- Reset values: ZBT_Address_O=0, ZBT_WE_n_O=1, ZBT_Data_O=0, ZBT_Data_OE_O=0, Rdata_O=0, all Valid_O=0, Flush_Done_O=0. While resetn is low, all Busy_O are forced to 1.
- Flush latency: Flush_I is sampled high at the end of cycle F. Flush_Done_O pulses in cycle F+RD_LATENCY+3. Accepted reads still return Valid during DRAIN.

## Test plan
- Fwd read at addr 0x00010 alone, ZBT model returning 0xA5A5_0010 → Fwd_Busy=0, ZBT_Address 0x00010 with WE_n=1 in T+1, Rdata_O=0xA5A5_0010 with only Fwd_Valid high in T+4.
- Disp, Wb and Fwd all requesting in the same cycle → Disp accepted first, then Wb, then Fwd in three consecutive cycles; the losers see Busy=1 until accepted.
- Fwd and Bwd both held requesting for 6 cycles → grants alternate Fwd, Bwd, Fwd, Bwd, Fwd, Bwd.
- Wb write of 0x1234_5678 to 0x00200, then a Disp read of 0x00200 in the next cycle → write data on ZBT_Data_O with OE=1 in T+3. The Disp read returns 0x1234_5678 with Disp_Valid in T+5.
- Fwd read accepted in cycle T, then Flush_I pulsed in T+1 together with a Bwd request → Bwd not accepted, Fwd_Valid in T+4, Flush_Done_O in T+6, Bwd accepted in T+7.
- resetn pulsed low one cycle after a Disp read is accepted → no Disp_Valid ever appears, ZBT_WE_n_O=1, and all Busy_O=1 during reset.
